alu_seq_multiplication: RTL and testbench
=========================================

// Module: alu_seq_multiplication
// PURPOSE
//  Iterative IEEE-754 single-precision multiplier, the inverse operation to the ALU divider. Computes a*b
//  with shift-add mantissa multiplication over MANT_W+1 cycles instead of a combinational array.
//  Sits beside the divider and adder/subtractor in the ALU datapath. Valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MANT_W  23   stored mantissa width (hidden bit excluded)
//  BIAS    127  exponent bias
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  a_operand  in   32  multiplicand, sampled only on the accept cycle
//  b_operand  in   32  multiplier, sampled only on the accept cycle
//  valid_in   in   1   operands valid
//  ready_out  out  1   block can accept (high only in IDLE)
//  result     out  32  product, held stable while valid_out=1
//  Exception  out  1   zero/denormal/inf/NaN operand, or exponent overflow/underflow; qualified by valid_out
//  valid_out  out  1   result valid
//  ready_in   in   1   downstream accepts result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready_out=1, valid_out=0, result=0, Exception=0, counter=0.
//  Accept: valid_in & ready_out at a rising edge; latch sign=a[31]^b[31], exponents, {1,mant} of each.
//  FSM: IDLE -> (accept) -> EXC if either exponent is 0 or all-ones, else MUL.
//   MUL : MANT_W+1 (24) cycles; each cycle if mplier[0] add mcand to 48-bit acc, shift mcand left,
//         mplier right; counter counts 0..23, leaves MUL when counter==23.
//   NORM: 1 cycle; exp = ea + eb - BIAS in 10-bit signed; if acc[47] mant=acc[46:24], exp+1,
//         else mant=acc[45:23]. Truncate (round toward zero); no sticky/guard rounding.
//         exp >= 255 -> result={sign,8'hFF,23'h0}, Exception=1.
//         exp <= 0   -> result={sign,31'h0}, Exception=1 (no denormal output).
//         else result={sign,exp[7:0],mant}, Exception=0. -> OUT.
//   EXC : 1 cycle; result={sign,31'h0}, Exception=1 -> OUT.
//   OUT : valid_out=1; result/Exception frozen; on ready_in=1 -> IDLE (valid_out drops next cycle).
//  Latency (normal): valid_out rises 26 edges after accept edge (24 MUL + NORM + OUT entry).
//  Latency (exception operand): valid_out rises 2 edges after accept edge.
//  ready_out=0 in MUL/NORM/EXC/OUT; valid_in ignored outside IDLE (no queuing, no overwrite).
//  Back-to-back: earliest next accept is the edge after the OUT->IDLE transfer edge (no same-cycle reuse).
//  Backpressure: ready_in low indefinitely holds OUT with unchanged outputs.
//  Reset mid-operation: any state returns to IDLE immediately; partial result discarded, valid_out=0.
//  Sign is computed even for exceptions (-0 * x gives Exception=1, result=32'h8000_0000 if x positive).
// STRUCTURE
//  Shared package (alu_fp_pkg): EXP_W, MANT_W, BIAS, FP_WIDTH=32, state enum {IDLE,MUL,NORM,EXC,OUT},
//   field-extract helpers (sign/exp/mant), is_special(exp) function shared with divider exception logic.
//  One sub-module: alu_shift_add_core (48-bit accumulator, shifting mcand/mplier, iteration counter,
//   start/done); FSM, exponent arithmetic and normalisation stay in the top.
// TESTING
//  1) a=3FC00000 (1.5), b=40000000 (2.0) -> result=40400000, Exception=0, valid_out 26 edges after accept.
//  2) a=C0200000 (-2.5), b=40800000 (4.0) -> result=C1200000; a=b=3FC00000 -> 40100000 (NORM with acc[47]).
//  3) a=00000000, b=40000000 -> Exception=1, result=00000000 after 2 edges; a=7F800000 -> Exception=1.
//  4) a=b=7F000000 -> Exception=1, result=7F800000; a=b=00800000 (min normal) -> Exception=1, 00000000.
//  5) Hold ready_in=0 for 10 cycles in OUT, toggle valid_in/operands -> result stable, ready_out=0,
//     no new accept; release -> one transfer, ready_out=1 next cycle.
//  6) Assert rst_n=0 asynchronously at MUL iteration 10 -> valid_out=0, ready_out=1 without clock edge;
//     next op 1.5*2.0 after release -> 40400000 with full latency.

Source files
------------

// File: rtl/alu_fp_pkg.sv
// rtl/alu_fp_pkg.sv - shared single-precision field layout, FSM states and helpers for the ALU FP units
package alu_fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int BIAS     = 127;
  localparam int FP_WIDTH = 32;
  localparam int PROD_W   = 2 * (MANT_W + 1);
  localparam int CNT_W    = $clog2(MANT_W + 1);
  localparam int EXPS_W   = EXP_W + 2;

  typedef enum logic [2:0] {IDLE, MUL, NORM, EXC, OUT} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;

  function automatic fp_t fp_unpack(input logic [FP_WIDTH-1:0] x);
    return fp_t'(x);
  endfunction

  // Zero/denormal and inf/NaN both take the exception path; shared with the divider.
  function automatic logic is_special(input logic [EXP_W-1:0] e);
    return (e == {EXP_W{1'b0}}) || (e == {EXP_W{1'b1}});
  endfunction

endpackage

// File: rtl/alu_shift_add_core.sv
// rtl/alu_shift_add_core.sv - iterative shift-add mantissa multiplier, one partial product per cycle
module alu_shift_add_core
  import alu_fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [MANT_W:0]   i_mcand,
  input  logic [MANT_W:0]   i_mplier,
  output logic [MANT_W+1:0] o_acc_hi,
  output logic              o_done
);

  logic [PROD_W-1:0] r_acc;
  logic [PROD_W-1:0] r_mcand;
  logic [MANT_W:0]   r_mplier;
  logic [CNT_W-1:0]  r_count;
  logic              r_busy;
  logic [PROD_W-1:0] w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign o_done   = r_busy && (r_count == CNT_W'(MANT_W));
  // Only the top bits matter to normalisation; the rest is truncated.
  assign o_acc_hi = r_acc[PROD_W-1 -: MANT_W+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{(MANT_W+1){1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= r_acc + w_addend;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_multiplication.sv
// rtl/alu_seq_multiplication.sv - iterative single-precision multiplier with valid/ready on both sides
module alu_seq_multiplication
  import alu_fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FP_WIDTH-1:0] a_operand,
  input  logic [FP_WIDTH-1:0] b_operand,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [FP_WIDTH-1:0] result,
  output logic                Exception,
  output logic                valid_out,
  input  logic                ready_in
);

  state_t              r_state, w_next_state;
  logic                r_sign;
  logic [EXP_W-1:0]    r_exp_a, r_exp_b;
  logic [FP_WIDTH-1:0] r_result;
  logic                r_exc;

  fp_t                 w_a, w_b;
  logic                w_accept, w_special, w_start, w_done;
  logic [MANT_W+1:0]   w_acc_hi;
  logic [EXPS_W-1:0]   w_exp;
  logic [MANT_W-1:0]   w_mant;
  logic                w_ovf, w_unf;
  logic [FP_WIDTH-1:0] w_norm_result;
  logic                w_norm_exc;

  assign w_a       = fp_unpack(a_operand);
  assign w_b       = fp_unpack(b_operand);
  assign ready_out = (r_state == IDLE);
  assign valid_out = (r_state == OUT);
  assign result    = r_result;
  assign Exception = r_exc;
  assign w_accept  = valid_in & ready_out;
  assign w_special = is_special(w_a.exp) | is_special(w_b.exp);
  assign w_start   = w_accept & ~w_special;

  alu_shift_add_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_mcand  ({1'b1, w_a.mant}),
    .i_mplier ({1'b1, w_b.mant}),
    .o_acc_hi (w_acc_hi),
    .o_done   (w_done)
  );

  // Product in [1,4): a set top bit means the binary point moves one place left.
  assign w_exp  = {2'b00, r_exp_a} + {2'b00, r_exp_b}
                + EXPS_W'(w_acc_hi[MANT_W+1]) - EXPS_W'(BIAS);
  assign w_mant = w_acc_hi[MANT_W+1] ? w_acc_hi[MANT_W:1] : w_acc_hi[MANT_W-1:0];
  assign w_ovf  = ~w_exp[EXPS_W-1] && (w_exp >= EXPS_W'(2**EXP_W - 1));
  assign w_unf  = w_exp[EXPS_W-1] || (w_exp == '0);

  always_comb begin
    w_norm_result = {r_sign, w_exp[EXP_W-1:0], w_mant};
    w_norm_exc    = 1'b0;
    if (w_ovf) begin
      w_norm_result = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      w_norm_exc    = 1'b1;
    end else if (w_unf) begin
      w_norm_result = {r_sign, {(FP_WIDTH-1){1'b0}}};
      w_norm_exc    = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (valid_in) w_next_state = w_special ? EXC : MUL;
      MUL:     if (w_done) w_next_state = NORM;
      NORM:    w_next_state = OUT;
      EXC:     w_next_state = OUT;
      OUT:     if (ready_in) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_exp_a  <= '0;
      r_exp_b  <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign  <= w_a.sign ^ w_b.sign;
        r_exp_a <= w_a.exp;
        r_exp_b <= w_b.exp;
      end
      if (r_state == NORM) begin
        r_result <= w_norm_result;
        r_exc    <= w_norm_exc;
      end else if (r_state == EXC) begin
        r_result <= {r_sign, {(FP_WIDTH-1){1'b0}}};
        r_exc    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_multiplication.sv
// tb/tb_alu_seq_multiplication.sv - scoreboard bench for the iterative FP multiplier
module tb_alu_seq_multiplication;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic        ready_out;
  logic [31:0] result;
  logic        Exception;
  logic        valid_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  alu_seq_multiplication dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .result    (result),
    .Exception (Exception),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact integer product of the hidden-bit mantissas, truncated.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic        s;
    int          ea, eb, ex;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || ea == 255 || eb == 0 || eb == 255) begin
      e.res = {s, 31'h0}; e.exc = 1'b1; e.lat = 2;
      return e;
    end
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex = ea + eb - 127;
    if (p[47]) begin m = p[46:24]; ex = ex + 1; end
    else       m = p[45:23];
    e.lat = 26;
    if (ex >= 255)    begin e.res = {s, 8'hFF, 23'h0}; e.exc = 1'b1; end
    else if (ex <= 0) begin e.res = {s, 31'h0};        e.exc = 1'b1; end
    else              begin e.res = {s, 8'(ex), m};    e.exc = 1'b0; end
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_operand = a; b_operand = b; valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ready_out) break;
      @(negedge clk);
    end
    if (!ready_out) begin
      total++; bad++;
      $display("FAIL issue_ready: ready_out never rose");
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Counts edges inclusive of the accept edge until valid_out is seen.
  task automatic wait_valid(output int edges, output bit ok);
    edges = 1; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_out) begin ok = 1'b1; break; end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic release_out();
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    total++; if (Exception !== 1'b0) begin bad++; $display("FAIL reset_exception: got %b want 0", Exception); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag, input logic [31:0] ta[4], input logic [31:0] tb[4],
                           input logic [31:0] tr[4], input logic te[4], input int tl[4]);
    int   edges;
    bit   ok;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.res = tr[k]; e.exc = te[k]; e.lat = tl[k];
      sb.push_back(e);
      issue(ta[k], tb[k]);
      wait_valid(edges, ok);
      e = sb.pop_front();
      total++; if (!ok) begin bad++; $display("FAIL %s_timeout[%0d]: valid_out never rose", tag, k); end
      total++; if (edges != e.lat) begin bad++; $display("FAIL %s_latency[%0d]: got %0d want %0d", tag, k, edges, e.lat); end
      total++; if (result !== e.res) begin bad++; $display("FAIL %s_result[%0d]: got %h want %h", tag, k, result, e.res); end
      total++; if (Exception !== e.exc) begin bad++; $display("FAIL %s_exc[%0d]: got %b want %b", tag, k, Exception, e.exc); end
      release_out();
      @(negedge clk);
      total++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
        bad++; $display("FAIL %s_handoff[%0d]: valid_out=%b ready_out=%b want 0/1", tag, k, valid_out, ready_out);
      end
    end
  endtask

  task automatic test_normal();
    logic [31:0] ta[4] = '{32'h3FC00000, 32'hC0200000, 32'h3FC00000, 32'h3F800000};
    logic [31:0] tb[4] = '{32'h40000000, 32'h40800000, 32'h3FC00000, 32'hBF800000};
    logic [31:0] tr[4] = '{32'h40400000, 32'hC1200000, 32'h40100000, 32'hBF800000};
    logic        te[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          tl[4] = '{26, 26, 26, 26};
    run_table("normal", ta, tb, tr, te, tl);
  endtask

  task automatic test_exceptions();
    logic [31:0] ta[4] = '{32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] tb[4] = '{32'h40000000, 32'h40000000, 32'h7F000000, 32'h00800000};
    logic [31:0] tr[4] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h00000000};
    logic        te[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    int          tl[4] = '{2, 2, 26, 26};
    run_table("exc", ta, tb, tr, te, tl);
  endtask

  task automatic test_neg_zero();
    int   edges;
    bit   ok;
    exp_t e;
    e.res = 32'h80000000; e.exc = 1'b1; e.lat = 2;
    sb.push_back(e);
    issue(32'h80000000, 32'h40000000);
    wait_valid(edges, ok);
    e = sb.pop_front();
    total++; if (!ok || edges != e.lat) begin bad++; $display("FAIL negzero_latency: got %0d want %0d", edges, e.lat); end
    total++; if (result !== e.res || Exception !== e.exc) begin
      bad++; $display("FAIL negzero_result: got %h/%b want %h/%b", result, Exception, e.res, e.exc);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int   edges;
    bit   ok;
    exp_t e;
    e.res = 32'h40100000; e.exc = 1'b0; e.lat = 26;
    sb.push_back(e);
    issue(32'h3FC00000, 32'h3FC00000);
    wait_valid(edges, ok);
    e = sb.pop_front();
    total++; if (!ok || result !== e.res) begin bad++; $display("FAIL bp_result: got %h want %h", result, e.res); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 valid_in = 1'b1; a_operand = $urandom; b_operand = $urandom;
      @(negedge clk);
      total++; if (result !== e.res || Exception !== e.exc || valid_out !== 1'b1 || ready_out !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: result=%h exc=%b valid=%b ready=%b want %h/%b/1/0",
                        i, result, Exception, valid_out, ready_out, e.res, e.exc);
      end
    end
    valid_in = 1'b0;
    release_out();
    @(negedge clk);
    total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      bad++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", ready_out, valid_out);
    end
    repeat (3) @(negedge clk);
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_no_accept: ready=%b want 1", ready_out); end
  endtask

  task automatic test_reset_mid();
    int   edges;
    bit   ok;
    exp_t e;
    issue(32'h3FC00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #2;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rstmid_busy: ready=%b want 0", ready_out); end
    rst_n = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL rstmid_async: valid=%b ready=%b want 0/1", valid_out, ready_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e.res = 32'h40400000; e.exc = 1'b0; e.lat = 26;
    sb.push_back(e);
    issue(32'h3FC00000, 32'h40000000);
    wait_valid(edges, ok);
    e = sb.pop_front();
    total++; if (!ok || edges != e.lat) begin bad++; $display("FAIL rstmid_latency: got %0d want %0d", edges, e.lat); end
    total++; if (result !== e.res || Exception !== e.exc) begin
      bad++; $display("FAIL rstmid_result: got %h/%b want %h/%b", result, Exception, e.res, e.exc);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int          edges;
    bit          ok;
    exp_t        e;
    logic [31:0] a, b;
    a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    sb.push_back(model(a, b));
    issue(a, b);
    for (int k = 0; k < 5; k++) begin
      wait_valid(edges, ok);
      e = sb.pop_front();
      total++; if (!ok || edges != e.lat) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, edges, e.lat); end
      total++; if (result !== e.res || Exception !== e.exc) begin
        bad++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", k, result, Exception, e.res, e.exc);
      end
      if (k == 4) begin
        release_out();
      end else begin
        a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        sb.push_back(model(a, b));
        a_operand = a; b_operand = b; valid_in = 1'b1; ready_in = 1'b1;
        @(posedge clk);
        #1 ready_in = 1'b0;
        @(negedge clk);
        total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
          bad++; $display("FAIL b2b_gap[%0d]: ready=%b valid=%b want 1/0", k, ready_out, valid_out);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_exceptions();
    test_neg_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
